// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU bus, loader port and memory port shared by mem_arbiter and its user
//   cpu_*   : T80 bus side (sel/mreq/rd/wr/rfsh/addr/din in, q/wait_n out)
//   ld_*    : host download port (download/wr/addr/data in, wait out)
//   mem_*   : single-port memory (addr/data/we out, q in)
//   cpu_reset: registered reset to the CPU
interface mem_arbiter_if #(parameter int ADDR_W = 16);
  logic              cpu_sel;
  logic              cpu_mreq_n;
  logic              cpu_rd_n;
  logic              cpu_wr_n;
  logic              cpu_rfsh_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_q;
  logic              cpu_wait_n;
  logic              ld_download;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_wait;
  logic              cpu_reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic [7:0]        mem_q;
  modport slave (
    input  cpu_sel, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_addr, cpu_din,
    input  ld_download, ld_wr, ld_addr, ld_data, mem_q,
    output cpu_q, cpu_wait_n, ld_wait, cpu_reset, mem_addr, mem_data, mem_we
  );
  modport master (
    output cpu_sel, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_addr, cpu_din,
    output ld_download, ld_wr, ld_addr, ld_data, mem_q,
    input  cpu_q, cpu_wait_n, ld_wait, cpu_reset, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the T80 CPU bus and a one-deep download write buffer
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : mem_arbiter_if slave modport (CPU bus, loader port, memory port, cpu_reset)
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CPU_RD, CPU_WR, LD_WR} state_t;
  state_t            state_q, state_d;
  logic              cpu_req, new_req, go_ld, go_cpu, complete, ld_acc;
  logic              cpu_req_d_q, cpu_req_d_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_done_q, cpu_done_d;
  logic              c_wr_q, c_wr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [7:0]        c_data_q, c_data_d;
  logic [7:0]        cpu_q_q, cpu_q_d;
  logic              ld_full_q, ld_full_d;
  logic              ld_prio_q, ld_prio_d;
  logic [ADDR_W-1:0] l_addr_q, l_addr_d;
  logic [7:0]        l_data_q, l_data_d;
  logic [7:0]        lat_q, lat_d;
  logic              cpu_reset_q;
  always_comb begin
    cpu_req  = bus.cpu_sel & ~bus.cpu_mreq_n & bus.cpu_rfsh_n & (~bus.cpu_rd_n | ~bus.cpu_wr_n);
    // a request rising while an aborted access is still pending is picked up once that access retires
    new_req  = cpu_req & ~cpu_req_d_q & ~cpu_pend_q;
    go_ld    = ld_full_q & (~cpu_pend_q | bus.ld_download | ld_prio_q);
    go_cpu   = cpu_pend_q & ~go_ld;
    complete = (state_q == CPU_WR) | ((state_q == CPU_RD) & (lat_q == 8'(RD_LAT - 1)));
    ld_acc   = bus.ld_wr & (~ld_full_q | (state_q == LD_WR));
    state_d  = (state_q == IDLE) ? (go_ld ? LD_WR : go_cpu ? (c_wr_q ? CPU_WR : CPU_RD) : IDLE)
             : ((state_q == CPU_RD) & ~complete) ? CPU_RD : IDLE;
    lat_d       = ((state_q == CPU_RD) & ~complete) ? lat_q + 8'd1 : 8'd0;
    // while pending, cpu_req_d only tracks a fall so an abort-then-re-request is seen as a fresh edge later
    cpu_req_d_d = cpu_pend_q ? (cpu_req_d_q & cpu_req) : cpu_req;
    cpu_pend_d  = new_req | (cpu_pend_q & ~complete);
    c_addr_d    = new_req ? bus.cpu_addr : c_addr_q;
    c_data_d    = new_req ? bus.cpu_din : c_data_q;
    c_wr_d      = new_req ? ~bus.cpu_wr_n : c_wr_q;
    // completion of an aborted access must not release a newer, not yet latched request
    cpu_done_d  = cpu_req & (cpu_done_q | (complete & cpu_req_d_q));
    cpu_q_d     = ((state_q == CPU_RD) & complete) ? bus.mem_q : cpu_q_q;
    ld_full_d   = ld_acc | (ld_full_q & (state_q != LD_WR));
    l_addr_d    = ld_acc ? bus.ld_addr : l_addr_q;
    l_data_d    = ld_acc ? bus.ld_data : l_data_q;
    ld_prio_d   = (state_q == LD_WR) ? 1'b0 : ld_prio_q | (complete & ld_full_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cpu_req_d_q <= 1'b0;
      cpu_pend_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      c_wr_q      <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      cpu_q_q     <= 8'hFF;
      ld_full_q   <= 1'b0;
      ld_prio_q   <= 1'b0;
      l_addr_q    <= '0;
      l_data_q    <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cpu_req_d_q <= cpu_req_d_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_done_q  <= cpu_done_d;
      c_wr_q      <= c_wr_d;
      c_addr_q    <= c_addr_d;
      c_data_q    <= c_data_d;
      cpu_q_q     <= cpu_q_d;
      ld_full_q   <= ld_full_d;
      ld_prio_q   <= ld_prio_d;
      l_addr_q    <= l_addr_d;
      l_data_q    <= l_data_d;
      cpu_reset_q <= bus.ld_download;
    end
  // the address is shown during the IDLE decision so a registered RAM has data by the first CPU_RD clock
  assign bus.mem_addr   = (state_q == CPU_RD || state_q == CPU_WR) ? c_addr_q
                        : (state_q == LD_WR) ? l_addr_q
                        : go_ld ? l_addr_q : go_cpu ? c_addr_q : '0;
  assign bus.mem_data   = (state_q == CPU_WR) ? c_data_q : (state_q == LD_WR) ? l_data_q : 8'h00;
  assign bus.mem_we     = (state_q == CPU_WR) | (state_q == LD_WR);
  assign bus.cpu_q      = cpu_q_q;
  assign bus.cpu_wait_n = ~(cpu_req & ~cpu_done_q);
  assign bus.ld_wait    = ld_full_q;
  assign bus.cpu_reset  = cpu_reset_q;
endmodule
